// File: rtl/apb_master_bridge_if.sv
// APB master bridge bus bundle: command channel, response channel and APB pins.
// master modport = bridge side, slave modport = controller/peripheral side.
interface apb_master_bridge_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 8
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic              PSEL;
  logic              PENABLE;
  logic [ADDR_W-1:0] PADDR;
  logic              PWRITE;
  logic [DATA_W-1:0] PWDATA;
  logic [DATA_W-1:0] PRDATA;
  logic              PREADY;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata,
    input  rsp_ready, PRDATA, PREADY,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err,
    output PSEL, PENABLE, PADDR, PWRITE, PWDATA
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata,
    output rsp_ready, PRDATA, PREADY,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err,
    input  PSEL, PENABLE, PADDR, PWRITE, PWDATA
  );
endinterface

// File: rtl/apb_master_bridge.sv
// APB initiator: one command -> one SETUP/ACCESS transfer -> one response.
// Ports: PCLK, PRESETN (async low), bus (apb_master_bridge_if.master).
// Optional macro APB_TIMEOUT_EN: abort ACCESS after TIMEOUT_CYCLES with rsp_err.
module apb_master_bridge #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 8,
  parameter int TIMEOUT_CYCLES = 16
) (
  input logic                  PCLK,
  input logic                  PRESETN,
  apb_master_bridge_if.master  bus
);

  if (TIMEOUT_CYCLES < 1) begin : g_bad_cfg
    $error("TIMEOUT_CYCLES must be >= 1");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETUP,
    S_ACCESS,
    S_RESP
  } state_t;

  state_t            r_state,   w_state_n;
  logic              r_psel,    w_psel_n;
  logic              r_penable, w_penable_n;
  logic [ADDR_W-1:0] r_paddr,   w_paddr_n;
  logic              r_pwrite,  w_pwrite_n;
  logic [DATA_W-1:0] r_pwdata,  w_pwdata_n;
  logic              r_rvalid,  w_rvalid_n;
  logic [DATA_W-1:0] r_rdata,   w_rdata_n;
  logic              r_rerr,    w_rerr_n;

`ifdef APB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  logic [CNT_W-1:0] r_cnt, w_cnt_n;
`endif

  always_comb begin
    w_state_n   = r_state;
    w_psel_n    = r_psel;
    w_penable_n = r_penable;
    w_paddr_n   = r_paddr;
    w_pwrite_n  = r_pwrite;
    w_pwdata_n  = r_pwdata;
    w_rvalid_n  = r_rvalid;
    w_rdata_n   = r_rdata;
    w_rerr_n    = r_rerr;
`ifdef APB_TIMEOUT_EN
    w_cnt_n     = r_cnt;
`endif
    unique case (r_state)
      S_IDLE: begin
        if (bus.cmd_valid) begin
          w_paddr_n  = bus.cmd_addr;
          w_pwrite_n = bus.cmd_write;
          w_pwdata_n = bus.cmd_wdata;
          w_psel_n   = 1'b1;
          w_state_n  = S_SETUP;
        end
      end
      S_SETUP: begin
        w_penable_n = 1'b1;
        w_state_n   = S_ACCESS;
`ifdef APB_TIMEOUT_EN
        w_cnt_n     = '0;
`endif
      end
      S_ACCESS: begin
        if (bus.PREADY) begin
          w_psel_n    = 1'b0;
          w_penable_n = 1'b0;
          w_rvalid_n  = 1'b1;
          w_rdata_n   = r_pwrite ? '0 : bus.PRDATA;
          w_rerr_n    = 1'b0;
          w_state_n   = S_RESP;
        end
`ifdef APB_TIMEOUT_EN
        else if (r_cnt == CNT_LAST) begin
          w_psel_n    = 1'b0;
          w_penable_n = 1'b0;
          w_rvalid_n  = 1'b1;
          w_rdata_n   = '0;
          w_rerr_n    = 1'b1;
          w_state_n   = S_RESP;
        end else begin
          w_cnt_n = r_cnt + 1'b1;
        end
`endif
      end
      S_RESP: begin
        if (bus.rsp_ready) begin
          w_rvalid_n = 1'b0;
          w_state_n  = S_IDLE;
        end
      end
      default: w_state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) begin
      r_state   <= S_IDLE;
      r_psel    <= 1'b0;
      r_penable <= 1'b0;
      r_paddr   <= '0;
      r_pwrite  <= 1'b0;
      r_pwdata  <= '0;
      r_rvalid  <= 1'b0;
      r_rdata   <= '0;
      r_rerr    <= 1'b0;
    end else begin
      r_state   <= w_state_n;
      r_psel    <= w_psel_n;
      r_penable <= w_penable_n;
      r_paddr   <= w_paddr_n;
      r_pwrite  <= w_pwrite_n;
      r_pwdata  <= w_pwdata_n;
      r_rvalid  <= w_rvalid_n;
      r_rdata   <= w_rdata_n;
      r_rerr    <= w_rerr_n;
    end
  end

`ifdef APB_TIMEOUT_EN
  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) r_cnt <= '0;
    else          r_cnt <= w_cnt_n;
  end
`endif

  assign bus.cmd_ready = (r_state == S_IDLE);
  assign bus.PSEL      = r_psel;
  assign bus.PENABLE   = r_penable;
  assign bus.PADDR     = r_paddr;
  assign bus.PWRITE    = r_pwrite;
  assign bus.PWDATA    = r_pwdata;
  assign bus.rsp_valid = r_rvalid;
  assign bus.rsp_rdata = r_rdata;
  assign bus.rsp_err   = r_rerr;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Directed bench for apb_master_bridge: cycle-exact APB/response checks,
// wait states, response backpressure, mid-transfer reset, optional timeout.
module tb_apb_master_bridge;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_run = 0;
  int   n_fail = 0;
  int   n_acc = 0;
  int   n_rsp = 0;

  always #5 clk = ~clk;

  apb_master_bridge_if #(.ADDR_W(32), .DATA_W(8)) bus ();

  apb_master_bridge #(
    .ADDR_W(32),
    .DATA_W(8),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .PCLK(clk),
    .PRESETN(rst_n),
    .bus(bus)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // protocol monitor
  logic        p_psel, p_pen;
  logic [31:0] p_addr;
  logic [7:0]  p_wdata;
  always @(negedge clk) begin
    if (!rst_n) begin
      p_psel = 1'b0;
      p_pen  = 1'b0;
    end else begin
      if (bus.PENABLE && !p_pen)
        chk("mon_setup", {30'd0, p_psel, p_pen}, 32'd2);
      if (bus.PENABLE)
        chk("mon_pen_sel", {31'd0, bus.PSEL}, 32'd1);
      if (bus.PSEL && p_psel) begin
        chk("mon_paddr", bus.PADDR, p_addr);
        chk("mon_pwdata", {24'd0, bus.PWDATA}, {24'd0, p_wdata});
      end
      p_psel  = bus.PSEL;
      p_pen   = bus.PENABLE;
      p_addr  = bus.PADDR;
      p_wdata = bus.PWDATA;
    end
  end

  task automatic run_xfer(input bit wr, input logic [31:0] a,
                          input logic [7:0] wd, input int nwait,
                          input logic [7:0] rd, input int rdly);
    logic [7:0] exp_rd;
    exp_rd = wr ? 8'h00 : rd;
    bus.cmd_valid = 1'b1;
    bus.cmd_write = wr;
    bus.cmd_addr  = a;
    bus.cmd_wdata = wd;
    bus.rsp_ready = 1'b0;
    bus.PREADY    = 1'b1;
    chk("acc_rdy", {31'd0, bus.cmd_ready}, 32'd1);
    n_acc++;
    tick();
    bus.cmd_valid = 1'b0;
    bus.PREADY    = 1'b1;
    chk("setup_psel", {31'd0, bus.PSEL}, 32'd1);
    chk("setup_pen", {31'd0, bus.PENABLE}, 32'd0);
    chk("setup_addr", bus.PADDR, a);
    chk("setup_wr", {31'd0, bus.PWRITE}, {31'd0, wr});
    chk("setup_wd", {24'd0, bus.PWDATA}, {24'd0, wd});
    chk("setup_rdy", {31'd0, bus.cmd_ready}, 32'd0);
    tick();
    for (int k = 0; k <= nwait; k++) begin
      bus.PREADY = (k == nwait);
      bus.PRDATA = (k == nwait) ? rd : 8'hEE;
      chk("acc_sel", {30'd0, bus.PSEL, bus.PENABLE}, 32'd3);
      chk("acc_addr", bus.PADDR, a);
      chk("acc_rv", {31'd0, bus.rsp_valid}, 32'd0);
      tick();
    end
    bus.PREADY = 1'b1;
    bus.PRDATA = 8'h99;
    for (int j = 0; j < rdly; j++) begin
      bus.cmd_valid = 1'b1;
      bus.cmd_addr  = ~a;
      chk("resp_rv", {31'd0, bus.rsp_valid}, 32'd1);
      chk("resp_rd", {24'd0, bus.rsp_rdata}, {24'd0, exp_rd});
      chk("resp_bus", {30'd0, bus.PSEL, bus.PENABLE}, 32'd0);
      chk("resp_crdy", {31'd0, bus.cmd_ready}, 32'd0);
      tick();
    end
    bus.cmd_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    chk("rsp_valid", {31'd0, bus.rsp_valid}, 32'd1);
    chk("rsp_rdata", {24'd0, bus.rsp_rdata}, {24'd0, exp_rd});
    chk("rsp_err", {31'd0, bus.rsp_err}, 32'd0);
    chk("rsp_bus", {30'd0, bus.PSEL, bus.PENABLE}, 32'd0);
    chk("rsp_hold_addr", bus.PADDR, a);
    if (bus.rsp_valid) n_rsp++;
    tick();
    bus.rsp_ready = 1'b0;
    chk("idle_rv", {31'd0, bus.rsp_valid}, 32'd0);
    chk("idle_rdy", {31'd0, bus.cmd_ready}, 32'd1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_wdata = '0;
    bus.rsp_ready = 1'b0;
    bus.PRDATA    = '0;
    bus.PREADY    = 1'b0;
    #23;
    chk("rst_sel", {30'd0, bus.PSEL, bus.PENABLE}, 32'd0);
    chk("rst_wr", {31'd0, bus.PWRITE}, 32'd0);
    chk("rst_addr", bus.PADDR, 32'd0);
    chk("rst_wd", {24'd0, bus.PWDATA}, 32'd0);
    chk("rst_rsp", {22'd0, bus.rsp_valid, bus.rsp_err, bus.rsp_rdata},
        32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("rst_rdy", {31'd0, bus.cmd_ready}, 32'd1);

    run_xfer(1'b1, 32'h0000_0004, 8'h5A, 0, 8'h77, 0);
    run_xfer(1'b0, 32'h0000_0008, 8'h00, 3, 8'hC3, 0);
    run_xfer(1'b0, 32'h0000_0020, 8'h00, 1, 8'h3C, 5);
    run_xfer(1'b0, 32'h0000_0024, 8'h00, 0, 8'hA5, 0);

    // reset during ACCESS of a write
    bus.cmd_valid = 1'b1;
    bus.cmd_write = 1'b1;
    bus.cmd_addr  = 32'h10;
    bus.cmd_wdata = 8'hFF;
    bus.PREADY    = 1'b0;
    bus.rsp_ready = 1'b1;
    tick();
    bus.cmd_valid = 1'b0;
    tick();
    chk("mid_acc", {30'd0, bus.PSEL, bus.PENABLE}, 32'd3);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_drop", {30'd0, bus.PSEL, bus.PENABLE}, 32'd0);
    chk("mid_rv", {31'd0, bus.rsp_valid}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.PREADY = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("post_rv", {31'd0, bus.rsp_valid}, 32'd0);
      chk("post_rdy", {31'd0, bus.cmd_ready}, 32'd1);
    end
    run_xfer(1'b1, 32'h0000_0004, 8'h11, 0, 8'h00, 0);

`ifdef APB_TIMEOUT_EN
    bus.cmd_valid = 1'b1;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = 32'h30;
    bus.rsp_ready = 1'b0;
    bus.PREADY    = 1'b0;
    bus.PRDATA    = 8'h55;
    n_acc++;
    tick();
    bus.cmd_valid = 1'b0;
    chk("to_setup", {30'd0, bus.PSEL, bus.PENABLE}, 32'd2);
    for (int k = 0; k < 16; k++) begin
      tick();
      chk("to_acc", {30'd0, bus.PSEL, bus.PENABLE}, 32'd3);
    end
    tick();
    chk("to_bus", {30'd0, bus.PSEL, bus.PENABLE}, 32'd0);
    chk("to_rv", {31'd0, bus.rsp_valid}, 32'd1);
    chk("to_err", {31'd0, bus.rsp_err}, 32'd1);
    chk("to_rd", {24'd0, bus.rsp_rdata}, 32'd0);
    if (bus.rsp_valid) n_rsp++;
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    run_xfer(1'b0, 32'h0000_0034, 8'h00, 15, 8'h6D, 0);
`endif

    for (int i = 0; i < 20; i++) begin
      run_xfer(1'($urandom_range(0, 1)), $urandom,
               8'($urandom), $urandom_range(0, 6),
               8'($urandom), $urandom_range(0, 3));
    end

    chk("sb_count", n_rsp, n_acc);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
